branch_predictor: RTL and testbench

Fetch-stage dynamic branch predictor. It predicts whether the current fetch PC is a taken conditional branch and supplies the target. It is trained by branch outcomes resolved in the computational stage, after condition evaluation has produced the final PC source. It also flags mispredictions and produces the corrected PC.

---
 rtl/branch_predictor.sv | 149 ++++++++++++++
 tb/tb_branch_predictor.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Fetch-stage dynamic branch predictor.
// A direct-mapped table of 2-bit saturating counters with tags and targets.
// Lookup is combinational from the fetch PC. Training comes from branches
// resolved in the execute stage and takes effect one cycle later.
// Two 32-bit counters track resolved branches and mispredictions.
module branch_predictor #(
    parameter int XLEN       = 32,
    parameter int INDEX_BITS = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] PCF,
    output logic            PredictTaken_F,
    output logic [XLEN-1:0] PredictedTarget_F,
    input  logic            ResolveValid_E,
    input  logic [XLEN-1:0] PC_E,
    input  logic            ActualTaken_E,
    input  logic [XLEN-1:0] ActualTarget_E,
    input  logic            PredictedTaken_E,
    input  logic [XLEN-1:0] PredictedTarget_E,
    output logic            Mispredict_E,
    output logic [XLEN-1:0] Redirect_E,
    output logic [31:0]     BranchCount,
    output logic [31:0]     MispredictCount
);

    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = XLEN - INDEX_BITS - 2;

    // Flattened views of the per-entry state, for indexed reads
    logic [ENTRIES-1:0]  valid_vec;
    logic [1:0]          ctr_vec    [ENTRIES];
    logic [TAG_BITS-1:0] tag_vec    [ENTRIES];
    logic [XLEN-1:0]     target_vec [ENTRIES];

    // Fetch-side lookup fields
    logic [INDEX_BITS-1:0] f_index;
    logic [TAG_BITS-1:0]   f_tag;
    logic                  f_hit;

    // Execute-side training fields
    logic [INDEX_BITS-1:0] e_index;
    logic [TAG_BITS-1:0]   e_tag;
    logic                  e_hit;
    logic [1:0]            e_ctr;
    logic [1:0]            e_ctr_next;
    logic                  resolve_en;
    logic                  update_hit;
    logic                  alloc;
    logic                  wrong_dir;
    logic                  wrong_tgt;

    logic [31:0] branch_count_reg;
    logic [31:0] mispredict_count_reg;

    assign f_index = PCF[INDEX_BITS+1:2];
    assign f_tag   = PCF[XLEN-1:INDEX_BITS+2];
    assign e_index = PC_E[INDEX_BITS+1:2];
    assign e_tag   = PC_E[XLEN-1:INDEX_BITS+2];

    // A resolution presented while reset is high is discarded entirely
    assign resolve_en = ResolveValid_E && !reset;

    // Prediction reads the current (pre-update) table; no bypass from training
    always_comb begin
        f_hit             = valid_vec[f_index] && (tag_vec[f_index] == f_tag);
        PredictTaken_F    = !reset && f_hit && ctr_vec[f_index][1];
        PredictedTarget_F = PredictTaken_F ? target_vec[f_index] : PCF + XLEN'(4);
    end

    // Misprediction check: wrong direction, or right direction with wrong target
    always_comb begin
        wrong_dir    = PredictedTaken_E != ActualTaken_E;
        wrong_tgt    = ActualTaken_E && PredictedTaken_E && (PredictedTarget_E != ActualTarget_E);
        Mispredict_E = resolve_en && (wrong_dir || wrong_tgt);
        Redirect_E   = ActualTaken_E ? ActualTarget_E : PC_E + XLEN'(4);
    end

    // Saturating counter step and training decision for the resolving entry
    always_comb begin
        e_hit = valid_vec[e_index] && (tag_vec[e_index] == e_tag);
        e_ctr = ctr_vec[e_index];
        if (ActualTaken_E) begin
            e_ctr_next = (e_ctr == 2'b11) ? 2'b11 : e_ctr + 2'd1;
        end else begin
            e_ctr_next = (e_ctr == 2'b00) ? 2'b00 : e_ctr - 2'd1;
        end
        update_hit = resolve_en && e_hit;
        alloc      = resolve_en && !e_hit && ActualTaken_E;
    end

    // One register slice per table entry; only the addressed entry trains
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic                valid_reg;
            logic [1:0]          ctr_reg;
            logic [TAG_BITS-1:0] tag_reg;
            logic [XLEN-1:0]     target_reg;
            logic                sel;

            assign sel = (e_index == INDEX_BITS'(gi));

            // Valid bit and counter: cleared to invalid / weakly-not-taken on reset
            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_reg <= 1'b0;
                    ctr_reg   <= 2'b01;
                end else if (sel && update_hit) begin
                    ctr_reg <= e_ctr_next;
                end else if (sel && alloc) begin
                    valid_reg <= 1'b1;
                    ctr_reg   <= 2'b10;
                end
            end

            // Tag and target are only meaningful when valid, so they carry no reset
            always_ff @(posedge clk) begin
                if (!reset && sel && (update_hit || alloc) && ActualTaken_E) begin
                    tag_reg    <= e_tag;
                    target_reg <= ActualTarget_E;
                end
            end

            assign valid_vec[gi]  = valid_reg;
            assign ctr_vec[gi]    = ctr_reg;
            assign tag_vec[gi]    = tag_reg;
            assign target_vec[gi] = target_reg;
        end
    endgenerate

    // Performance counters, free-running and wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_count_reg     <= '0;
            mispredict_count_reg <= '0;
        end else begin
            if (resolve_en) begin
                branch_count_reg <= branch_count_reg + 32'd1;
            end
            if (Mispredict_E) begin
                mispredict_count_reg <= mispredict_count_reg + 32'd1;
            end
        end
    end

    assign BranchCount     = branch_count_reg;
    assign MispredictCount = mispredict_count_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table walking the main
// training scenarios, then randomized traffic against a table-level model,
// then a mid-stream reset sequence.
module tb_branch_predictor;

    logic        clk;
    logic        reset;
    logic [31:0] PCF;
    logic        PredictTaken_F;
    logic [31:0] PredictedTarget_F;
    logic        ResolveValid_E;
    logic [31:0] PC_E;
    logic        ActualTaken_E;
    logic [31:0] ActualTarget_E;
    logic        PredictedTaken_E;
    logic [31:0] PredictedTarget_E;
    logic        Mispredict_E;
    logic [31:0] Redirect_E;
    logic [31:0] BranchCount;
    logic [31:0] MispredictCount;

    int checks = 0;
    int errors = 0;

    branch_predictor #(.XLEN(32), .INDEX_BITS(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .PCF               (PCF),
        .PredictTaken_F    (PredictTaken_F),
        .PredictedTarget_F (PredictedTarget_F),
        .ResolveValid_E    (ResolveValid_E),
        .PC_E              (PC_E),
        .ActualTaken_E     (ActualTaken_E),
        .ActualTarget_E    (ActualTarget_E),
        .PredictedTaken_E  (PredictedTaken_E),
        .PredictedTarget_E (PredictedTarget_E),
        .Mispredict_E      (Mispredict_E),
        .Redirect_E        (Redirect_E),
        .BranchCount       (BranchCount),
        .MispredictCount   (MispredictCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (table of 16 entries) ----------------
    bit          m_valid [16];
    int unsigned m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    int unsigned m_bc;
    int unsigned m_mc;

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc >> 2) % 32'd16);
    endfunction

    function automatic int unsigned tag_of(logic [31:0] pc);
        return pc >> 6;
    endfunction

    function automatic bit m_pred(logic [31:0] pc);
        int i;
        i = idx_of(pc);
        return !reset && m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
    endfunction

    function automatic logic [31:0] m_ptgt(logic [31:0] pc);
        return m_pred(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_mis();
        return ResolveValid_E && !reset &&
               ((PredictedTaken_E != ActualTaken_E) ||
                (ActualTaken_E && (PredictedTarget_E != ActualTarget_E)));
    endfunction

    function automatic logic [31:0] m_redirect();
        return ActualTaken_E ? ActualTarget_E : PC_E + 32'd4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_bc = 0;
        m_mc = 0;
    endtask

    task automatic model_clock();
        int  i;
        bit  hit;
        if (reset) begin
            model_reset();
        end else if (ResolveValid_E) begin
            m_bc++;
            if (m_mis()) m_mc++;
            i   = idx_of(PC_E);
            hit = m_valid[i] && (m_tag[i] == tag_of(PC_E));
            if (hit && ActualTaken_E) begin
                m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                m_tgt[i] = ActualTarget_E;
            end else if (hit) begin
                m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
            end else if (ActualTaken_E) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = tag_of(PC_E);
                m_tgt[i]   = ActualTarget_E;
                m_ctr[i]   = 2;
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge with inputs already driven: optional combinational
    // check against the model, then clock, then counter check.
    task automatic do_cycle(input bit use_model, input string tag);
        #1;
        if (use_model) begin
            check({tag, " pt_f"}, 32'(PredictTaken_F), 32'(m_pred(PCF)));
            check({tag, " tgt_f"}, PredictedTarget_F, m_ptgt(PCF));
            check({tag, " mis"}, 32'(Mispredict_E), 32'(m_mis()));
            if (m_mis()) check({tag, " redirect"}, Redirect_E, m_redirect());
        end
        @(posedge clk);
        model_clock();
        @(negedge clk);
        check({tag, " branch_count"}, BranchCount, m_bc);
        check({tag, " mispredict_count"}, MispredictCount, m_mc);
    endtask

    task automatic idle_inputs();
        ResolveValid_E    = 1'b0;
        PC_E              = 32'h0;
        ActualTaken_E     = 1'b0;
        ActualTarget_E    = 32'h0;
        PredictedTaken_E  = 1'b0;
        PredictedTarget_E = 32'h0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] pcf;
        bit          rv;
        logic [31:0] pce;
        bit          at;
        logic [31:0] atgt;
        bit          pt;
        logic [31:0] ptgt;
        bit          e_pf;
        logic [31:0] e_tf;
        bit          e_mis;
        logic [31:0] e_red;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(logic [31:0] pcf, bit rv, logic [31:0] pce, bit at,
                                logic [31:0] atgt, bit pt, logic [31:0] ptgt,
                                bit e_pf, logic [31:0] e_tf, bit e_mis, logic [31:0] e_red);
        vec_t v;
        v.pcf = pcf; v.rv = rv; v.pce = pce; v.at = at; v.atgt = atgt;
        v.pt = pt; v.ptgt = ptgt; v.e_pf = e_pf; v.e_tf = e_tf;
        v.e_mis = e_mis; v.e_red = e_red;
        return v;
    endfunction

    function automatic logic [31:0] pick_pc();
        logic [31:0] pc;
        if ($urandom_range(0, 9) == 0) begin
            pc = 32'hFFFF_FFFC;
        end else begin
            pc = 32'h100 + 32'($urandom_range(0, 3) << 6) + 32'($urandom_range(0, 15) << 2);
        end
        return pc;
    endfunction

    function automatic logic [31:0] pick_tgt();
        logic [31:0] t;
        case ($urandom_range(0, 3))
            0:       t = 32'h80;
            1:       t = 32'h90;
            2:       t = 32'h200;
            default: t = $urandom & 32'hFFFF_FFFC;
        endcase
        return t;
    endfunction

    initial begin
        //            pcf          rv pce          at atgt   pt ptgt         pf tf           mis red
        vecs[0]  = mk(32'h100,      0, 32'h0,       0, 32'h0,   0, 32'h0,      0, 32'h104,      0, 32'h0);
        vecs[1]  = mk(32'h100,      1, 32'h100,     1, 32'h80,  0, 32'h104,    0, 32'h104,      1, 32'h80);
        vecs[2]  = mk(32'h100,      0, 32'h0,       0, 32'h0,   0, 32'h0,      1, 32'h80,       0, 32'h0);
        vecs[3]  = mk(32'h100,      1, 32'h100,     1, 32'h80,  1, 32'h80,     1, 32'h80,       0, 32'h0);
        vecs[4]  = mk(32'h100,      1, 32'h100,     1, 32'h80,  1, 32'h80,     1, 32'h80,       0, 32'h0);
        vecs[5]  = mk(32'h100,      1, 32'h100,     1, 32'h80,  1, 32'h80,     1, 32'h80,       0, 32'h0);
        vecs[6]  = mk(32'h100,      1, 32'h100,     0, 32'h80,  1, 32'h80,     1, 32'h80,       1, 32'h104);
        vecs[7]  = mk(32'h100,      0, 32'h0,       0, 32'h0,   0, 32'h0,      1, 32'h80,       0, 32'h0);
        vecs[8]  = mk(32'h100,      1, 32'h100,     0, 32'h80,  1, 32'h80,     1, 32'h80,       1, 32'h104);
        vecs[9]  = mk(32'h100,      0, 32'h0,       0, 32'h0,   0, 32'h0,      0, 32'h104,      0, 32'h0);
        vecs[10] = mk(32'h100,      1, 32'h100,     1, 32'h80,  0, 32'h104,    0, 32'h104,      1, 32'h80);
        vecs[11] = mk(32'h100,      0, 32'h0,       0, 32'h0,   0, 32'h0,      1, 32'h80,       0, 32'h0);
        vecs[12] = mk(32'h140,      1, 32'h140,     1, 32'h200, 0, 32'h144,    0, 32'h144,      1, 32'h200);
        vecs[13] = mk(32'h100,      0, 32'h0,       0, 32'h0,   0, 32'h0,      0, 32'h104,      0, 32'h0);
        vecs[14] = mk(32'h140,      0, 32'h0,       0, 32'h0,   0, 32'h0,      1, 32'h200,      0, 32'h0);
        vecs[15] = mk(32'h140,      1, 32'h304,     1, 32'h90,  1, 32'h80,     1, 32'h200,      1, 32'h90);
        vecs[16] = mk(32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0, 32'h0,  1, 32'h10,     0, 32'h0,        1, 32'h0);
        vecs[17] = mk(32'h304,      0, 32'h100,     0, 32'h0,   1, 32'h80,     1, 32'h90,       0, 32'h0);

        // Initial reset cycle
        model_reset();
        reset = 1'b1;
        PCF   = 32'h100;
        idle_inputs();
        do_cycle(1, "reset");
        reset = 1'b0;

        // Directed table
        for (int n = 0; n < 18; n++) begin
            string tag;
            tag               = $sformatf("vec%0d", n);
            PCF               = vecs[n].pcf;
            ResolveValid_E    = vecs[n].rv;
            PC_E              = vecs[n].pce;
            ActualTaken_E     = vecs[n].at;
            ActualTarget_E    = vecs[n].atgt;
            PredictedTaken_E  = vecs[n].pt;
            PredictedTarget_E = vecs[n].ptgt;
            #1;
            check({tag, " pt_f"}, 32'(PredictTaken_F), 32'(vecs[n].e_pf));
            check({tag, " tgt_f"}, PredictedTarget_F, vecs[n].e_tf);
            check({tag, " mis"}, 32'(Mispredict_E), 32'(vecs[n].e_mis));
            if (vecs[n].e_mis) check({tag, " redirect"}, Redirect_E, vecs[n].e_red);
            $display("%s pcf=%h rv=%0d pce=%h at=%0d pt_f=%0d tgt_f=%h mis=%0d",
                     tag, PCF, ResolveValid_E, PC_E, ActualTaken_E,
                     PredictTaken_F, PredictedTarget_F, Mispredict_E);
            do_cycle(0, tag);
        end
        check("table branch_count", BranchCount, 32'd10);
        check("table mispredict_count", MispredictCount, 32'd7);

        // Randomized traffic against the model, from a clean reset
        reset = 1'b1;
        idle_inputs();
        do_cycle(1, "rreset");
        reset = 1'b0;
        for (int n = 0; n < 500; n++) begin
            PCF               = pick_pc();
            ResolveValid_E    = ($urandom_range(0, 3) != 0);
            PC_E              = pick_pc();
            ActualTaken_E     = $urandom_range(0, 1) == 1;
            ActualTarget_E    = pick_tgt();
            if ($urandom_range(0, 1) == 1) begin
                PredictedTaken_E  = m_pred(PC_E);
                PredictedTarget_E = m_ptgt(PC_E);
            end else begin
                PredictedTaken_E  = $urandom_range(0, 1) == 1;
                PredictedTarget_E = pick_tgt();
            end
            $display("rand%0d pcf=%h rv=%0d pce=%h at=%0d atgt=%h pt=%0d ptgt=%h",
                     n, PCF, ResolveValid_E, PC_E, ActualTaken_E, ActualTarget_E,
                     PredictedTaken_E, PredictedTarget_E);
            do_cycle(1, $sformatf("rand%0d", n));
        end

        // Train 0x100 so a reset has something to wipe
        PCF               = 32'h100;
        ResolveValid_E    = 1'b1;
        PC_E              = 32'h100;
        ActualTaken_E     = 1'b1;
        ActualTarget_E    = 32'h80;
        PredictedTaken_E  = 1'b0;
        PredictedTarget_E = 32'h104;
        do_cycle(1, "pretrain");
        PCF = 32'h100;
        idle_inputs();
        #1;
        check("pretrain pt_f", 32'(PredictTaken_F), 32'd1);

        // Reset mid-stream with a resolution presented: it must be discarded
        reset             = 1'b1;
        PCF               = 32'h100;
        ResolveValid_E    = 1'b1;
        PC_E              = 32'h140;
        ActualTaken_E     = 1'b1;
        ActualTarget_E    = 32'h300;
        PredictedTaken_E  = 1'b0;
        PredictedTarget_E = 32'h144;
        #1;
        check("midreset pt_f", 32'(PredictTaken_F), 32'd0);
        check("midreset tgt_f", PredictedTarget_F, 32'h104);
        check("midreset mis", 32'(Mispredict_E), 32'd0);
        $display("midreset pcf=%h pce=%h pt_f=%0d mis=%0d", PCF, PC_E, PredictTaken_F, Mispredict_E);
        @(posedge clk);
        model_clock();
        @(negedge clk);
        check("midreset branch_count", BranchCount, 32'd0);
        check("midreset mispredict_count", MispredictCount, 32'd0);
        reset = 1'b0;
        idle_inputs();
        for (int i = 0; i < 16; i++) begin
            for (int t = 0; t < 4; t++) begin
                PCF = 32'h100 + 32'(t << 6) + 32'(i << 2);
                #1;
                check($sformatf("postreset pt_f %h", PCF), 32'(PredictTaken_F), 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
